// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding
// and the oversampling divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int calc_div(
    input int clock_hz,
    input int baud,
    input int os
  );
    return clock_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider, one-CLOCK TICK every DIV cycles.
// Ports: CLOCK, RESET (sync, active high), TICK (registered pulse).
module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic CLOCK,
  input  logic RESET,
  output logic TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      TICK <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver, 3-sample majority vote per bit.
// Ports: CLOCK, RESET (sync), RX line in; DATA/VALID/READY handshake;
// PARITY_ERR, FRAME_ERR per word; OVERRUN pulse on a dropped word.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN
);

  localparam int DIV = calc_div(CLOCK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic       HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic       ODD_PAR   = (PARITY == PAR_ODD);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_os: tick divisor below 2");
  end

  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
  end

  logic tick;

  uart_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .TICK  (tick)
  );

  logic rx_m;
  logic rx_s;
  logic rx_d;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  rx_state_t            state;
  logic [SW-1:0]        s;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 smp0;
  logic                 smp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;

  logic vote;
  logic fall;
  logic vtick;

  // Third sample is the live synced line at s = OS/2+1.
  assign vote  = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign fall  = rx_d & ~rx_s;
  assign vtick = tick && (s == S_V2);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      s          <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      smp0       <= 1'b1;
      smp1       <= 1'b1;
      shreg      <= '0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      DATA       <= '0;
      VALID      <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      OVERRUN <= 1'b0;
      if (VALID && READY) VALID <= 1'b0;

      if (state != ST_IDLE && tick) begin
        s <= (s == S_END) ? '0 : s + 1'b1;
        if (s == S_V0) smp0 <= rx_s;
        if (s == S_V1) smp1 <= rx_s;
      end

      unique case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            s        <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
          end
        end
        ST_START: begin
          if (vtick && vote) begin
            state <= ST_IDLE;
          end else if (tick && s == S_END) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (vtick) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
          end
          if (tick && s == S_END) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= HAS_PAR ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (vtick) begin
            par_err <= ((^shreg) ^ vote) != ODD_PAR;
          end
          if (tick && s == S_END) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (vtick) begin
            if (!vote) frm_err <= 1'b1;
            if (stop_cnt == LAST_STOP) begin
              // Finish at the vote, not at s wrap, to catch
              // a back-to-back start edge half a bit early.
              state <= ST_IDLE;
              if (!VALID || READY) begin
                DATA       <= shreg;
                PARITY_ERR <= par_err;
                FRAME_ERR  <= frm_err | ~vote;
                VALID      <= 1'b1;
              end else begin
                OVERRUN <= 1'b1;
              end
            end
          end
          if (tick && s == S_END) begin
            stop_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed tests over 8N1, 8E1 and 8N2 receivers
// sharing one clock/reset, each fed from a routed serial line.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int CHZ      = 1_600_000;
  localparam int BD       = 10_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic rx_drv = 1'b1;
  int   sel    = 0;

  logic rx_n1, rx_e1, rx_n2;
  assign rx_n1 = (sel == 0) ? rx_drv : 1'b1;
  assign rx_e1 = (sel == 1) ? rx_drv : 1'b1;
  assign rx_n2 = (sel == 2) ? rx_drv : 1'b1;

  logic       rdy_n1 = 1'b1;
  logic       rdy_e1 = 1'b1;
  logic       rdy_n2 = 1'b1;
  logic [7:0] d_n1, d_e1, d_n2;
  logic       v_n1, v_e1, v_n2;
  logic       pe_n1, pe_e1, pe_n2;
  logic       fe_n1, fe_e1, fe_n2;
  logic       ov_n1, ov_e1, ov_n2;

  uart_rx_os #(
    .CLOCK_HZ(CHZ), .BAUD(BD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_n1 (
    .CLOCK(clk), .RESET(rst), .RX(rx_n1),
    .DATA(d_n1), .VALID(v_n1), .READY(rdy_n1),
    .PARITY_ERR(pe_n1), .FRAME_ERR(fe_n1), .OVERRUN(ov_n1)
  );

  uart_rx_os #(
    .CLOCK_HZ(CHZ), .BAUD(BD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) u_e1 (
    .CLOCK(clk), .RESET(rst), .RX(rx_e1),
    .DATA(d_e1), .VALID(v_e1), .READY(rdy_e1),
    .PARITY_ERR(pe_e1), .FRAME_ERR(fe_e1), .OVERRUN(ov_e1)
  );

  uart_rx_os #(
    .CLOCK_HZ(CHZ), .BAUD(BD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)
  ) u_n2 (
    .CLOCK(clk), .RESET(rst), .RX(rx_n2),
    .DATA(d_n2), .VALID(v_n2), .READY(rdy_n2),
    .PARITY_ERR(pe_n2), .FRAME_ERR(fe_n2), .OVERRUN(ov_n2)
  );

  int n_pass = 0;
  int n_tot  = 0;

  int         acc_n1 = 0;
  int         ovc_n1 = 0;
  logic [7:0] cap_n1 [4];
  logic       cpe_n1, cfe_n1;
  int         acc_e1 = 0;
  logic [7:0] cap_e1;
  logic       cpe_e1, cfe_e1;
  int         acc_n2 = 0;
  logic [7:0] cap_n2;
  logic       cpe_n2, cfe_n2;

  always @(negedge clk) begin
    if (v_n1 && rdy_n1) begin
      if (acc_n1 < 4) cap_n1[acc_n1] = d_n1;
      cpe_n1 = pe_n1;
      cfe_n1 = fe_n1;
      acc_n1++;
    end
    if (ov_n1) ovc_n1++;
    if (v_e1 && rdy_e1) begin
      cap_e1 = d_e1;
      cpe_e1 = pe_e1;
      cfe_e1 = fe_e1;
      acc_e1++;
    end
    if (v_n2 && rdy_n2) begin
      cap_n2 = d_n2;
      cpe_n2 = pe_n2;
      cfe_n2 = fe_n2;
      acc_n2++;
    end
  end

  task automatic clr_mon();
    acc_n1 = 0;
    ovc_n1 = 0;
    acc_e1 = 0;
    acc_n2 = 0;
  endtask

  task automatic send_bits(input logic [15:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = fr[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tot++;
    if (d_n1 !== 8'h00) $display("FAIL rst_data got %h want 00", d_n1);
    else n_pass++;
    n_tot++;
    if (v_n1 !== 1'b0) $display("FAIL rst_valid got %b want 0", v_n1);
    else n_pass++;
    n_tot++;
    if (pe_n1 !== 1'b0 || fe_n1 !== 1'b0)
      $display("FAIL rst_flags got pe=%b fe=%b want 0 0", pe_n1, fe_n1);
    else n_pass++;
    n_tot++;
    if (ov_n1 !== 1'b0) $display("FAIL rst_ovr got %b want 0", ov_n1);
    else n_pass++;
    n_tot++;
    if (u_n1.state !== ST_IDLE)
      $display("FAIL rst_state got %0d want %0d", u_n1.state, ST_IDLE);
    else n_pass++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_8n1();
    sel = 0;
    clr_mon();
    send_bits({6'h3f, 1'b1, 8'h55, 1'b0}, 10);
    repeat (40) @(negedge clk);
    n_tot++;
    if (acc_n1 != 1) $display("FAIL n1_count got %0d want 1", acc_n1);
    else n_pass++;
    n_tot++;
    if (cap_n1[0] !== 8'h55) $display("FAIL n1_data got %h want 55", cap_n1[0]);
    else n_pass++;
    n_tot++;
    if (cpe_n1 !== 1'b0 || cfe_n1 !== 1'b0)
      $display("FAIL n1_flags got pe=%b fe=%b want 0 0", cpe_n1, cfe_n1);
    else n_pass++;
  endtask

  task automatic test_parity();
    sel = 1;
    clr_mon();
    send_bits({5'h1f, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
    repeat (40) @(negedge clk);
    n_tot++;
    if (acc_e1 != 1 || cap_e1 !== 8'hA3)
      $display("FAIL par_bad_data got n=%0d %h want n=1 a3", acc_e1, cap_e1);
    else n_pass++;
    n_tot++;
    if (cpe_e1 !== 1'b1) $display("FAIL par_bad_flag got %b want 1", cpe_e1);
    else n_pass++;
    send_bits({5'h1f, 1'b1, 1'b0, 8'hA3, 1'b0}, 11);
    repeat (40) @(negedge clk);
    n_tot++;
    if (acc_e1 != 2 || cap_e1 !== 8'hA3)
      $display("FAIL par_ok_data got n=%0d %h want n=2 a3", acc_e1, cap_e1);
    else n_pass++;
    n_tot++;
    if (cpe_e1 !== 1'b0 || cfe_e1 !== 1'b0)
      $display("FAIL par_ok_flags got pe=%b fe=%b want 0 0", cpe_e1, cfe_e1);
    else n_pass++;
    sel = 0;
  endtask

  task automatic test_false_start();
    sel = 0;
    clr_mon();
    rx_drv = 1'b0;
    repeat (40) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    n_tot++;
    if (acc_n1 != 0) $display("FAIL glitch_count got %0d want 0", acc_n1);
    else n_pass++;
    n_tot++;
    if (u_n1.state !== ST_IDLE)
      $display("FAIL glitch_state got %0d want %0d", u_n1.state, ST_IDLE);
    else n_pass++;
    send_bits({6'h3f, 1'b1, 8'h0F, 1'b0}, 10);
    repeat (40) @(negedge clk);
    n_tot++;
    if (acc_n1 != 1 || cap_n1[0] !== 8'h0F)
      $display("FAIL glitch_next got n=%0d %h want n=1 0f", acc_n1, cap_n1[0]);
    else n_pass++;
  endtask

  task automatic test_frame();
    sel = 2;
    clr_mon();
    send_bits({4'hf, 1'b0, 1'b1, 8'h3C, 1'b0}, 12);
    repeat (40) @(negedge clk);
    n_tot++;
    if (acc_n2 != 1 || cap_n2 !== 8'h3C)
      $display("FAIL frm_data got n=%0d %h want n=1 3c", acc_n2, cap_n2);
    else n_pass++;
    n_tot++;
    if (cfe_n2 !== 1'b1 || cpe_n2 !== 1'b0)
      $display("FAIL frm_flags got fe=%b pe=%b want 1 0", cfe_n2, cpe_n2);
    else n_pass++;
    sel = 0;
  endtask

  task automatic test_back_to_back();
    sel = 0;
    clr_mon();
    send_bits({6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
    send_bits({6'h3f, 1'b1, 8'h5A, 1'b0}, 10);
    repeat (40) @(negedge clk);
    n_tot++;
    if (acc_n1 != 2) $display("FAIL b2b_count got %0d want 2", acc_n1);
    else n_pass++;
    n_tot++;
    if (cap_n1[0] !== 8'hA5 || cap_n1[1] !== 8'h5A)
      $display("FAIL b2b_data got %h %h want a5 5a", cap_n1[0], cap_n1[1]);
    else n_pass++;
  endtask

  task automatic test_overrun();
    sel = 0;
    clr_mon();
    rdy_n1 = 1'b0;
    send_bits({6'h3f, 1'b1, 8'h11, 1'b0}, 10);
    send_bits({6'h3f, 1'b1, 8'h22, 1'b0}, 10);
    repeat (40) @(negedge clk);
    n_tot++;
    if (v_n1 !== 1'b1 || d_n1 !== 8'h11)
      $display("FAIL ovr_hold got v=%b %h want v=1 11", v_n1, d_n1);
    else n_pass++;
    n_tot++;
    if (ovc_n1 != 1) $display("FAIL ovr_pulses got %0d want 1", ovc_n1);
    else n_pass++;
    @(posedge clk);
    #1 rdy_n1 = 1'b1;
    @(posedge clk);
    #1;
    n_tot++;
    if (v_n1 !== 1'b0) $display("FAIL ovr_accept got v=%b want 0", v_n1);
    else n_pass++;
    n_tot++;
    if (d_n1 !== 8'h11) $display("FAIL ovr_keep got %h want 11", d_n1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    clr_mon();
    rx_drv = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    rx_drv = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tot++;
    if (d_n1 !== 8'h00 || v_n1 !== 1'b0)
      $display("FAIL mid_rst_out got v=%b %h want v=0 00", v_n1, d_n1);
    else n_pass++;
    n_tot++;
    if (pe_n1 !== 1'b0 || fe_n1 !== 1'b0 || ov_n1 !== 1'b0)
      $display("FAIL mid_rst_flags got %b%b%b want 000", pe_n1, fe_n1, ov_n1);
    else n_pass++;
    n_tot++;
    if (u_n1.state !== ST_IDLE)
      $display("FAIL mid_rst_state got %0d want %0d", u_n1.state, ST_IDLE);
    else n_pass++;
    repeat (200) @(negedge clk);
    send_bits({6'h3f, 1'b1, 8'h66, 1'b0}, 10);
    repeat (40) @(negedge clk);
    n_tot++;
    if (acc_n1 != 1 || cap_n1[0] !== 8'h66)
      $display("FAIL mid_next got n=%0d %h want n=1 66", acc_n1, cap_n1[0]);
    else n_pass++;
    n_tot++;
    if (cpe_n1 !== 1'b0 || cfe_n1 !== 1'b0)
      $display("FAIL mid_next_flags got pe=%b fe=%b want 0 0", cpe_n1, cfe_n1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_frame();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
